// File: rtl/alu_exec.sv
// alu_exec: execute stage of the 8-bit datapath.
// Single-cycle ALU ops write back one cycle after issue. MUL is an iterative
// 8-step shift-add multiply that is present only when ALU_EXEC_MUL_EN is
// defined. Without that macro, opcode 8 is illegal and busy is tied low.
module alu_exec (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] opcode,
   input  logic [7:0] operandA,
   input  logic [7:0] operandB,
   input  logic [2:0] dest_in,
   output logic [7:0] result,
   output logic [7:0] mulHigh_out,
   output logic [2:0] dest_out,
   output logic       writeEn,
   output logic       busy,
   output logic       zero,
   output logic       carry,
   output logic       err
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
`ifdef ALU_EXEC_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd8;
`endif
   localparam logic [3:0] OP_PASS = 4'd9;

   logic [7:0] alu_res;
   logic       alu_carry;
   logic       op_legal;
   logic       op_mul;

   // Decode the opcode and compute the single-cycle result and carry.
   always_comb begin
      // NOTE: every variable gets a default first so that no path can infer a latch.
      alu_res   = '0;
      alu_carry = 1'b0;
      op_legal  = 1'b1;
      op_mul    = 1'b0;
      case (opcode)
         OP_ADD:  {alu_carry, alu_res} = {1'b0, operandA} + {1'b0, operandB};
         OP_SUB: begin
            alu_res   = operandA - operandB;
            alu_carry = (operandA < operandB);
         end
         OP_AND:  alu_res = operandA & operandB;
         OP_OR:   alu_res = operandA | operandB;
         OP_XOR:  alu_res = operandA ^ operandB;
         OP_NOT:  alu_res = ~operandA;
         OP_SHL: begin
            alu_res   = {operandA[6:0], 1'b0};
            alu_carry = operandA[7];
         end
         OP_SHR: begin
            alu_res   = {1'b0, operandA[7:1]};
            alu_carry = operandA[0];
         end
`ifdef ALU_EXEC_MUL_EN
         OP_MUL:  op_mul = 1'b1;
`endif
         OP_PASS: alu_res = operandA;
         default: op_legal = 1'b0;
      endcase
   end

`ifdef ALU_EXEC_MUL_EN
   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q;
   logic [7:0] mcand_q;
   logic [7:0] hi_q, lo_q;
   logic [2:0] dest_q;
   logic [8:0] mul_sum;
   logic [7:0] hi_next, lo_next;
   logic       mul_last;

   assign mul_last = (cnt_q == 3'd7);
   assign busy     = (state_q == S_MUL);

   // Next-state logic: a MUL issue enters S_MUL, and the eighth step returns the FSM to S_IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && op_mul) state_d = S_MUL;
         S_MUL:   if (mul_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 9'd0);
      hi_next = mul_sum[8:1];
      lo_next = {mul_sum[0], lo_q[7:1]};
   end

   // State register, iteration counter and partial-product registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         if (busy) begin
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            cnt_q <= cnt_q + 3'd1;
         end else if (start && op_mul) begin
            mcand_q <= operandA;
            hi_q    <= '0;
            lo_q    <= operandB;
            cnt_q   <= '0;
            dest_q  <= dest_in;
         end
      end
   end
`else
   assign busy = 1'b0;
`endif

   // Architectural outputs change only on a write. err pulses for one cycle on an illegal issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         result      <= '0;
         mulHigh_out <= '0;
         dest_out    <= '0;
         writeEn     <= 1'b0;
         zero        <= 1'b0;
         carry       <= 1'b0;
         err         <= 1'b0;
      end else begin
         writeEn <= 1'b0;
         err     <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
         if (busy) begin
            if (mul_last) begin
               result      <= lo_next;
               mulHigh_out <= hi_next;
               dest_out    <= dest_q;
               zero        <= ({hi_next, lo_next} == 16'd0);
               carry       <= 1'b0;
               writeEn     <= 1'b1;
            end
         end else
`endif
         if (start) begin
            if (!op_legal) begin
               err <= 1'b1;
            end else if (!op_mul) begin
               result      <= alu_res;
               mulHigh_out <= '0;
               dest_out    <= dest_in;
               zero        <= (alu_res == 8'd0);
               carry       <= alu_carry;
               writeEn     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and random checks of alu_exec against an arithmetic
// reference model. It follows ALU_EXEC_MUL_EN the same way the design does.
module tb_alu_exec;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] opcode;
   logic [7:0] operandA;
   logic [7:0] operandB;
   logic [2:0] dest_in;
   logic [7:0] result;
   logic [7:0] mulHigh_out;
   logic [2:0] dest_out;
   logic       writeEn;
   logic       busy;
   logic       zero;
   logic       carry;
   logic       err;

   int vectors     = 0;
   int miscompares = 0;

`ifdef ALU_EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   // Values the model expects on the registered outputs.
   logic [7:0] m_result = '0;
   logic [7:0] m_high   = '0;
   logic [2:0] m_dest   = '0;
   logic       m_zero   = 1'b0;
   logic       m_carry  = 1'b0;

   alu_exec dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .opcode     (opcode),
      .operandA   (operandA),
      .operandB   (operandB),
      .dest_in    (dest_in),
      .result     (result),
      .mulHigh_out(mulHigh_out),
      .dest_out   (dest_out),
      .writeEn    (writeEn),
      .busy       (busy),
      .zero       (zero),
      .carry      (carry),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic we, input logic bsy, input logic er);
      check({tag, ".result"},  {8'h00, result},       {8'h00, m_result});
      check({tag, ".mulHigh"}, {8'h00, mulHigh_out},  {8'h00, m_high});
      check({tag, ".dest"},    {13'h0, dest_out},     {13'h0, m_dest});
      check({tag, ".zero"},    {15'h0, zero},         {15'h0, m_zero});
      check({tag, ".carry"},   {15'h0, carry},        {15'h0, m_carry});
      check({tag, ".writeEn"}, {15'h0, writeEn},      {15'h0, we});
      check({tag, ".busy"},    {15'h0, busy},         {15'h0, bsy});
      check({tag, ".err"},     {15'h0, err},          {15'h0, er});
   endtask

   // Reference arithmetic for one operation, computed with plain integers.
   function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output bit legal, output logic [7:0] r, output logic [7:0] h,
                                 output logic z, output logic c);
      int s;
      legal = 1'b1;
      s     = 0;
      r     = '0;
      h     = '0;
      c     = 1'b0;
      case (op)
         4'd0: begin s = int'(a) + int'(b); r = s[7:0]; c = (s > 255); end
         4'd1: begin s = int'(a) - int'(b); r = s[7:0]; c = (a < b); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = 8'(255 - int'(a));
         4'd6: begin s = int'(a) * 2; r = s[7:0]; c = (a >= 8'd128); end
         4'd7: begin r = 8'(int'(a) / 2); c = (int'(a) % 2 == 1); end
         4'd8: begin
            legal = MUL_EN;
            s = int'(a) * int'(b);
            r = s[7:0];
            h = s[15:8];
         end
         4'd9: r = a;
         default: legal = 1'b0;
      endcase
      z = (op == 4'd8) ? (s == 0) : (r == 8'd0);
   endfunction

   task automatic model_reset();
      m_result = '0;
      m_high   = '0;
      m_dest   = '0;
      m_zero   = 1'b0;
      m_carry  = 1'b0;
   endtask

   // Issue one operation and follow it to its write (or err). start stays high afterwards.
   task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] d);
      bit         legal;
      logic [7:0] r, h;
      logic       z, c;
      model(op, a, b, legal, r, h, z, c);
      start = 1'b1; opcode = op; operandA = a; operandB = b; dest_in = d;
      if (legal && op == 4'd8) begin
         tick();
         check_state({tag, ".e0"}, 1'b0, 1'b1, 1'b0);
         for (int i = 1; i <= 7; i++) begin
            // Garbage issue requests while busy must be ignored.
            start    = 1'b1;
            opcode   = 4'($urandom_range(15));
            operandA = 8'($urandom);
            operandB = 8'($urandom);
            dest_in  = 3'($urandom);
            tick();
            check_state({tag, ".busy"}, 1'b0, 1'b1, 1'b0);
         end
         opcode = 4'($urandom_range(15));
         tick();
         m_result = r; m_high = h; m_dest = d; m_zero = z; m_carry = c;
         check_state({tag, ".wr"}, 1'b1, 1'b0, 1'b0);
      end else begin
         tick();
         if (legal) begin
            m_result = r; m_high = h; m_dest = d; m_zero = z; m_carry = c;
         end
         check_state({tag, ".wr"}, legal, 1'b0, !legal);
      end
   endtask

   task automatic idle(input string tag);
      start = 1'b0;
      tick();
      check_state(tag, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; opcode = '0; operandA = '0; operandB = '0; dest_in = '0;
      tick();
      tick();
      rst = 1'b0;
      check_state("reset", 1'b0, 1'b0, 1'b0);

      // ADD wraps to zero with carry out.
      do_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 3'd3);
      check("add_ff_01.res_const", {8'h00, result}, 16'h0000);
      check("add_ff_01.carry_const", {15'h0, carry}, 16'h0001);
      check("add_ff_01.zero_const", {15'h0, zero}, 16'h0001);
      check("add_ff_01.dest_const", {13'h0, dest_out}, 16'h0003);
      idle("add_ff_01.after");

      do_op("sub_10_20", 4'd1, 8'h10, 8'h20, 3'd1);
      check("sub_10_20.res_const", {8'h00, result}, 16'h00F0);
      check("sub_10_20.carry_const", {15'h0, carry}, 16'h0001);
      idle("sub_10_20.after");

      do_op("shr_81", 4'd7, 8'h81, 8'h00, 3'd2);
      check("shr_81.res_const", {8'h00, result}, 16'h0040);
      check("shr_81.carry_const", {15'h0, carry}, 16'h0001);
      idle("shr_81.after");

      // MUL FF*FF, then MUL 0C*0A followed by an ADD in the write cycle.
      do_op("mul_ff_ff", 4'd8, 8'hFF, 8'hFF, 3'd4);
      idle("mul_ff_ff.after");
      do_op("mul_0c_0a", 4'd8, 8'h0C, 8'h0A, 3'd6);
      do_op("add_b2b", 4'd0, 8'h11, 8'h22, 3'd5);
      idle("add_b2b.after");

      // Reset during the fourth MUL cycle aborts the multiply.
      start = 1'b1; opcode = 4'd8; operandA = 8'h37; operandB = 8'h55; dest_in = 3'd7;
      tick();
      start = 1'b0;
      check_state("abort.c1", 1'b0, MUL_EN, !MUL_EN);
      tick();
      check_state("abort.c2", 1'b0, MUL_EN, 1'b0);
      tick();
      check_state("abort.c3", 1'b0, MUL_EN, 1'b0);
      tick();
      check_state("abort.c4", 1'b0, MUL_EN, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_state("abort.rst", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) idle("abort.quiet");
      do_op("pass_5a", 4'd9, 8'h5A, 8'h00, 3'd2);
      check("pass_5a.res_const", {8'h00, result}, 16'h005A);
      idle("pass_5a.after");

      // Reset and start on the same edge: reset wins.
      rst = 1'b1; start = 1'b1; opcode = 4'd0; operandA = 8'h01; operandB = 8'h01; dest_in = 3'd1;
      tick();
      rst = 1'b0; start = 1'b0;
      model_reset();
      check_state("rst_start", 1'b0, 1'b0, 1'b0);

      // Illegal opcode holds prior outputs.
      do_op("pass_c3", 4'd9, 8'hC3, 8'h00, 3'd5);
      do_op("illegal_12", 4'd12, 8'h12, 8'h34, 3'd1);
      idle("illegal_12.after");
      do_op("op8", 4'd8, 8'h03, 8'h05, 3'd2);
      idle("op8.after");

      // Random back-to-back traffic with occasional idle cycles.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(7) == 0) begin
            idle("rand.idle");
         end else begin
            do_op("rand", 4'($urandom_range(15)), 8'($urandom), 8'($urandom), 3'($urandom));
         end
      end
      idle("rand.end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
